// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx, sequences start/data/parity/stop bits
// against an external baud down-counter, and reports each frame with one-cycle pulses.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 cnt_done,
    input  logic [CNT_W-1:0]     cnt_value,
    output logic                 cnt_en,
    output logic                 cnt_soft_rst,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam logic        ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic                 rx_m;
    logic                 rx_s;
    logic                 rx_d;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_mis;
    logic                 sample;

    // Mid-bit sample point of the current bit period
    assign sample       = (state != IDLE) && (cnt_value == CNT_W'(HALF));
    assign cnt_soft_rst = (state == IDLE);
    assign cnt_en       = (state != IDLE);
    assign busy         = (state != IDLE);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            par_mis    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state   <= START;
                        par_mis <= 1'b0;
                    end
                end
                START: begin
                    if (sample && rx_s) begin
                        state <= IDLE;
                    end else if (cnt_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                    end
                    if (cnt_done) begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (sample) begin
                        par_mis <= (^shreg) ^ rx_s ^ ODD;
                    end
                    if (cnt_done) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Frame ends mid stop bit so an immediately following start edge is seen
                    if (sample) begin
                        state <= IDLE;
                        if (rx_s) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            parity_err <= par_mis;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 and an 8E1 instance, each with a behavioural baud
// counter, checked every cycle against a frame-timing model plus literal expectations.
module tb_uart_rx_ctrl;

    localparam int unsigned CPB = 16;
    localparam int unsigned CW  = 4;
    // Rx fall to data_valid: 3 cycles to START, 17 in START, 8*16 data, 8 into stop
    localparam int unsigned LAT_VALID = 156;
    localparam int unsigned LAT_BUSY  = 3;

    typedef struct {
        int          inst;
        int unsigned vcyc;
        int unsigned bfrom;
        int unsigned bto;
        logic        valid;
        logic        ferr;
        logic        perr;
        logic [7:0]  data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        rx;
    logic [1:0]        cdone;
    logic [1:0]        en;
    logic [1:0]        srst;
    logic [1:0]        dv;
    logic [1:0]        pe;
    logic [1:0]        fe;
    logic [1:0]        busy;
    logic [1:0][CW-1:0] cval;
    logic [1:0][7:0]   dout;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    exp_t        q[$];
    logic [1:0][7:0] mdout = '0;
    int          vcount[2] = '{0, 0};
    int          fcount[2] = '{0, 0};
    int unsigned last_v[2] = '{0, 0};
    int unsigned prev_v[2] = '{0, 0};
    logic        last_pe[2] = '{1'b0, 1'b0};
    logic        ev, ef, ep, eb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
        .clk(clk), .rst(rst), .rx(rx[0]), .cnt_done(cdone[0]), .cnt_value(cval[0]),
        .cnt_en(en[0]), .cnt_soft_rst(srst[0]), .data_out(dout[0]), .data_valid(dv[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .busy(busy[0])
    );

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .rx(rx[1]), .cnt_done(cdone[1]), .cnt_value(cval[1]),
        .cnt_en(en[1]), .cnt_soft_rst(srst[1]), .data_out(dout[1]), .data_valid(dv[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .busy(busy[1])
    );

    // Baud down-counters: reload on soft reset, done in the cycle after reaching zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                cval[k]  <= CW'(CPB - 1);
                cdone[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (srst[k]) begin
                    cval[k]  <= CW'(CPB - 1);
                    cdone[k] <= 1'b0;
                end else if (en[k]) begin
                    if (cval[k] == CW'(0)) begin
                        cval[k]  <= CW'(CPB - 1);
                        cdone[k] <= 1'b1;
                    end else begin
                        cval[k]  <= cval[k] - CW'(1);
                        cdone[k] <= 1'b0;
                    end
                end else begin
                    cdone[k] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the frame-timing model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ev = 1'b0; ef = 1'b0; ep = 1'b0; eb = 1'b0;
            foreach (q[i]) begin
                if (q[i].inst == k) begin
                    if ((q[i].valid || q[i].ferr) && q[i].vcyc == cyc) begin
                        ev = q[i].valid;
                        ef = q[i].ferr;
                        ep = q[i].perr;
                        if (q[i].valid) mdout[k] = q[i].data;
                    end
                    if (cyc >= q[i].bfrom && cyc < q[i].bto) eb = 1'b1;
                end
            end
            if (dv[k] === 1'b1) begin
                vcount[k]++;
                prev_v[k]  = last_v[k];
                last_v[k]  = cyc;
                last_pe[k] = pe[k];
            end
            if (fe[k] === 1'b1) fcount[k]++;
            chk("data_valid", k, 32'(dv[k]), 32'(ev));
            chk("frame_err", k, 32'(fe[k]), 32'(ef));
            chk("parity_err", k, 32'(pe[k]), 32'(ep));
            chk("busy", k, 32'(busy[k]), 32'(eb));
            chk("cnt_en", k, 32'(en[k]), 32'(eb));
            chk("cnt_soft_rst", k, 32'(srst[k]), 32'(!eb));
            chk("data_out", k, 32'(dout[k]), 32'(mdout[k]));
        end
        while (q.size() > 0 && q[0].bto < cyc && q[0].vcyc < cyc) void'(q.pop_front());
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int k, input logic b);
        rx[k] = b;
        idle(CPB);
    endtask

    // Sends one frame starting at posedge+1; returns at posedge+1 after the stop bit
    task automatic send(input int k, input logic [7:0] d, input logic par, input logic pbit, input logic stopb);
        exp_t e;
        e.inst  = k;
        e.bfrom = cyc + LAT_BUSY;
        e.vcyc  = cyc + LAT_VALID + (par ? CPB : 0);
        e.bto   = e.vcyc;
        e.valid = stopb;
        e.ferr  = !stopb;
        e.perr  = par && stopb && ((^d) ^ pbit);
        e.data  = d;
        q.push_back(e);
        drive_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
        if (par) drive_bit(k, pbit);
        drive_bit(k, stopb);
    endtask

    initial begin
        exp_t e;
        logic [7:0] pd;
        rst = 1'b0;
        rx  = 2'b11;
        #1;
        chk("reset data_out", 0, 32'(dout[0]), 32'h0);
        chk("reset busy", 0, 32'(busy[0]), 32'h0);
        chk("reset cnt_soft_rst", 0, 32'(srst[0]), 32'h1);
        chk("reset cnt_en", 0, 32'(en[0]), 32'h0);
        idle(3);
        rst = 1'b1;
        idle(5);

        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("A5 data_out", 0, 32'(dout[0]), 32'hA5);
        chk("A5 valid count", 0, 32'(vcount[0]), 32'd1);
        chk("A5 parity_err", 0, 32'(last_pe[0]), 32'h0);
        idle(10);

        // Short low glitch: START aborts at its sample point
        e.inst = 0; e.bfrom = cyc + LAT_BUSY; e.bto = cyc + 12; e.vcyc = 0;
        e.valid = 1'b0; e.ferr = 1'b0; e.perr = 1'b0; e.data = 8'h00;
        q.push_back(e);
        rx[0] = 1'b0;
        idle(5);
        rx[0] = 1'b1;
        idle(30);
        chk("false start valid count", 0, 32'(vcount[0]), 32'd1);

        send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(40);
        chk("framing err count", 0, 32'(fcount[0]), 32'd1);
        chk("framing err data_out", 0, 32'(dout[0]), 32'hA5);
        chk("framing err valid count", 0, 32'(vcount[0]), 32'd1);
        rx[0] = 1'b1;
        idle(30);

        send(0, 8'h55, 1'b0, 1'b0, 1'b1);
        send(0, 8'hAA, 1'b0, 1'b0, 1'b1);
        chk("b2b data_out", 0, 32'(dout[0]), 32'hAA);
        chk("b2b valid count", 0, 32'(vcount[0]), 32'd3);
        chk("b2b spacing", 0, last_v[0] - prev_v[0], 32'd160);
        idle(10);

        send(1, 8'h07, 1'b1, 1'b0, 1'b1);
        chk("bad parity flag", 1, 32'(last_pe[1]), 32'h1);
        chk("bad parity data_out", 1, 32'(dout[1]), 32'h07);
        idle(10);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1);
        chk("good parity flag", 1, 32'(last_pe[1]), 32'h0);
        chk("parity valid count", 1, 32'(vcount[1]), 32'd2);
        idle(10);

        // Reset in the middle of data bit 3
        pd = 8'h5A;
        e.inst = 0; e.bfrom = cyc + LAT_BUSY; e.bto = cyc + 100000; e.vcyc = 0;
        e.valid = 1'b0; e.ferr = 1'b0; e.perr = 1'b0; e.data = 8'h00;
        q.push_back(e);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, pd[i]);
        rx[0] = pd[3];
        idle(10);
        chk("pre-reset busy", 0, 32'(busy[0]), 32'h1);
        #2;
        rst = 1'b0;
        q.delete();
        mdout = '0;
        rx[0] = 1'b1;
        #1;
        chk("mid-frame reset data_out", 0, 32'(dout[0]), 32'h0);
        chk("mid-frame reset data_out p", 1, 32'(dout[1]), 32'h0);
        chk("mid-frame reset busy", 0, 32'(busy[0]), 32'h0);
        chk("mid-frame reset cnt_soft_rst", 0, 32'(srst[0]), 32'h1);
        chk("mid-frame reset cnt_en", 0, 32'(en[0]), 32'h0);
        idle(5);
        rst = 1'b1;
        idle(20);

        send(0, 8'h81, 1'b0, 1'b0, 1'b1);
        chk("post-reset data_out", 0, 32'(dout[0]), 32'h81);
        chk("post-reset valid count", 0, 32'(vcount[0]), 32'd4);
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
